// File: rtl/seq_chunk_adder_pkg.sv
// seq_chunk_adder_pkg: shared state encoding, default sizes and counter-width helper.
package seq_chunk_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/seq_chunk_adder_rca_chunk.sv
// rca_chunk: combinational ripple-carry adder built from full adders; also exposes the carry into its MSB.
module rca_chunk #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o,
  output logic         c_msb_o
);
  logic [W:0] c;
  assign c[0] = c_i;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign c_o     = c[W];
  assign c_msb_o = c[W-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/sub that pushes CHUNK bits per cycle through one ripple chain,
// keeping the inter-chunk carry in a register; valid/ready on both sides.
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_w(NCHUNK);
  if (CHUNK < 1 || CHUNK > WIDTH || WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      off;
  logic [CHUNK-1:0] sum;
  logic             cy, cy_msb;
  assign off = {{(32-CW){1'b0}}, cnt_q} * CHUNK;
  rca_chunk #(.W(CHUNK)) u_rca (
    .a_i    (a_q[off +: CHUNK]),
    .b_i    (b_q[off +: CHUNK]),
    .c_i    (carry_q),
    .s_o    (sum),
    .c_o    (cy),
    .c_msb_o(cy_msb)
  );
  // b is stored pre-inverted for subtraction so RUN is a plain add
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        a_d     = a;
        b_d     = sub ? ~b : b;
        carry_d = sub ? 1'b1 : c_in;
        cnt_d   = '0;
        s_d     = '0;
        state_d = RUN;
      end
    end else if (state_q == RUN) begin
      s_d[off +: CHUNK] = sum;
      carry_d           = cy;
      cnt_d             = cnt_q + 1'b1;
      if (cnt_q == CW'(NCHUNK - 1)) begin
        c_out_d = cy;
        ovf_d   = cy_msb ^ cy;
        state_d = DONE;
      end
    end else if (out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign zero      = out_valid && (s_q == '0);
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: drives three instances (CHUNK 8, 32, 1) and checks them against an arithmetic reference.
module tb_seq_chunk_adder;
  localparam int W = 32;
  function automatic int chs(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 32 : 1);
  endfunction
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [2:0]        in_valid, out_ready, in_ready, out_valid, c_out, ovf, zero;
  logic [W-1:0]      a, b;
  logic              c_in, sub;
  logic [2:0][W-1:0] s;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_chunk_adder #(.WIDTH(W), .CHUNK(chs(g))) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .s(s[g]), .c_out(c_out[g]), .ovf(ovf[g]), .zero(zero[g])
    );
  end
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // reference from the arithmetic definition: signed range for ovf, unsigned range for c_out
  task automatic ref_op(input logic [W-1:0] av, bv, input logic ci, sb,
                        output logic [W-1:0] rs, output logic rc, rv, rz);
    longint sa, sbv, sr;
    longint unsigned ua, ub, ur;
    sa  = longint'($signed(av));
    sbv = longint'($signed(bv));
    ua  = longint'(av);
    ub  = longint'(bv);
    sr  = sb ? sa - sbv : sa + sbv + longint'(ci);
    ur  = sb ? ua - ub : ua + ub + longint'(ci);
    rs  = ur[W-1:0];
    rc  = sb ? (ua >= ub) : (ur > 64'hFFFF_FFFF);
    rv  = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
    rz  = (rs == '0);
  endtask
  task automatic launch(input int k, input logic [W-1:0] av, bv, input logic ci, sb);
    int t = 0;
    while (!in_ready[k] && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_idle", in_ready[k], 1);
    a = av; b = bv; c_in = ci; sub = sb;
    in_valid[k] = 1'b1;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a = $urandom; b = $urandom; c_in = 1'($urandom); sub = 1'($urandom);
    chk("in_ready_busy", in_ready[k], 0);
  endtask
  task automatic wait_done(input int k, input int lat);
    int n = 0;
    while (!out_valid[k] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
  endtask
  task automatic check_res(input int k, input logic [W-1:0] av, bv, input logic ci, sb);
    logic [W-1:0] rs;
    logic rc, rv, rz;
    ref_op(av, bv, ci, sb, rs, rc, rv, rz);
    chk("s", s[k], rs);
    chk("c_out", c_out[k], rc);
    chk("ovf", ovf[k], rv);
    chk("zero", zero[k], rz);
    chk("in_ready_done", in_ready[k], 0);
  endtask
  task automatic release_out(input int k);
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    chk("out_valid_drop", out_valid[k], 0);
    chk("in_ready_back", in_ready[k], 1);
  endtask
  task automatic do_op(input int k, input logic [W-1:0] av, bv, input logic ci, sb);
    launch(k, av, bv, ci, sb);
    wait_done(k, W / chs(k));
    check_res(k, av, bv, ci, sb);
    release_out(k);
  endtask
  task automatic check_reset_vals(input int k);
    chk("rst_in_ready", in_ready[k], 1);
    chk("rst_out_valid", out_valid[k], 0);
    chk("rst_s", s[k], 0);
    chk("rst_c_out", c_out[k], 0);
    chk("rst_ovf", ovf[k], 0);
    chk("rst_zero", zero[k], 0);
  endtask
  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [W-1:0] ra, rb;
    logic [W-1:0] rs;
    logic rc, rv, rz;
    in_valid = '0; out_ready = '0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      do_op(k, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
      do_op(k, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    end
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    do_op(0, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) begin
      out_ready[0] = 1'($urandom);
      do_op(0, pick(), pick(), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 6; i++) begin
      do_op(1, pick(), pick(), 1'($urandom), 1'($urandom));
      do_op(2, pick(), pick(), 1'($urandom), 1'($urandom));
    end
    launch(0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
    wait_done(0, 4);
    a = 32'h8000_0000; b = 32'h8000_0000; c_in = 1'b0; sub = 1'b0;
    in_valid[0] = 1'b1;
    ref_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, rs, rc, rv, rz);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid[0], 1);
      chk("hold_s", s[0], rs);
      chk("hold_c_out", c_out[0], rc);
      chk("hold_in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    chk("hold_release_valid", out_valid[0], 0);
    chk("hold_release_ready", in_ready[0], 1);
    @(posedge clk); #1;
    chk("second_accepted", in_ready[0], 0);
    in_valid[0] = 1'b0;
    wait_done(0, 4);
    check_res(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    release_out(0);
    ra = 32'h1234_5678; rb = 32'h0101_0101;
    launch(0, ra, rb, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals(0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
